// File: rtl/bus_xcvr_pkg.sv
// Shared constants and FSM encoding for the byte-lane bus transceiver.
package bus_xcvr_pkg;
  localparam int   LANE_W = 8;
  localparam logic DIR_AB = 1'b1;
  localparam logic DIR_BA = 1'b0;

  // ST_ prefix keeps the turnaround state clear of the TURN length parameter.
  typedef enum logic [1:0] {
    ST_DRV_AB = 2'd0,
    ST_DRV_BA = 2'd1,
    ST_TURN   = 2'd2
  } xcvr_state_e;
endpackage

// File: rtl/bus_xcvr_lane.sv
// One byte lane: source mux, hold register and the registered pad enables.
module bus_xcvr_lane
  import bus_xcvr_pkg::*;
#(
  parameter bit LATCHED = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              src_ab_i,
  input  logic              le_i,
  input  logic              oe_n_i,
  input  logic              nxt_ab_i,
  input  logic              nxt_ba_i,
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] a_o,
  output logic [LANE_W-1:0] b_o,
  output logic              a_oe_o,
  output logic              b_oe_o
);
  logic [LANE_W-1:0] hold_q, hold_d;
  logic              a_oe_q, a_oe_d, b_oe_q, b_oe_d;

  // Masked lanes keep capturing so data is current when they are re-enabled.
  always_comb begin
    hold_d = hold_q;
    if (le_i) hold_d = (src_ab_i == DIR_AB) ? a_i : b_i;
    b_oe_d = nxt_ab_i & ~oe_n_i;
    a_oe_d = nxt_ba_i & ~oe_n_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q <= '0;
      a_oe_q <= 1'b0;
      b_oe_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      a_oe_q <= a_oe_d;
      b_oe_q <= b_oe_d;
    end
  end

  assign b_o    = LATCHED ? hold_q : a_i;
  assign a_o    = LATCHED ? hold_q : b_i;
  assign a_oe_o = a_oe_q;
  assign b_oe_o = b_oe_q;
endmodule

// File: rtl/bus_xcvr.sv
// Direction FSM with turnaround counter driving an array of byte lanes.
module bus_xcvr
  import bus_xcvr_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int TURN    = 2,
  parameter bit LATCHED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    dir_req,
  input  logic [LANES-1:0]        oe_n_req,
  input  logic                    le,
  input  logic [LANE_W*LANES-1:0] a_i,
  input  logic [LANE_W*LANES-1:0] b_i,
  output logic [LANE_W*LANES-1:0] a_o,
  output logic [LANE_W*LANES-1:0] b_o,
  output logic [LANES-1:0]        a_oe,
  output logic [LANES-1:0]        b_oe,
  output logic                    dir,
  output logic                    busy
);
  localparam logic [3:0] CNT_INIT = 4'(TURN - 1);

  xcvr_state_e state_q, state_d;
  logic        tgt_q, tgt_d, dir_q, dir_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        nxt_ab, nxt_ba;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_DRV_AB, ST_DRV_BA: begin
        if (dir_req != dir_q) begin
          state_d = ST_TURN;
          tgt_d   = dir_req;
          dir_d   = dir_req;
          cnt_d   = CNT_INIT;
        end
      end
      ST_TURN: begin
        // A request flip mid-turnaround restarts the full dead time.
        if (dir_req != tgt_q) begin
          tgt_d = dir_req;
          dir_d = dir_req;
          cnt_d = CNT_INIT;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = (tgt_q == DIR_AB) ? ST_DRV_AB : ST_DRV_BA;
        end
      end
      default: state_d = ST_TURN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_TURN;
      tgt_q   <= DIR_BA;
      dir_q   <= DIR_BA;
      cnt_q   <= CNT_INIT;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nxt_ab = (state_d == ST_DRV_AB);
  assign nxt_ba = (state_d == ST_DRV_BA);
  assign busy   = (state_q == ST_TURN);
  assign dir    = dir_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bus_xcvr_lane #(.LATCHED(LATCHED)) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .src_ab_i (dir_q),
      .le_i     (le),
      .oe_n_i   (oe_n_req[l]),
      .nxt_ab_i (nxt_ab),
      .nxt_ba_i (nxt_ba),
      .a_i      (a_i[l*LANE_W +: LANE_W]),
      .b_i      (b_i[l*LANE_W +: LANE_W]),
      .a_o      (a_o[l*LANE_W +: LANE_W]),
      .b_o      (b_o[l*LANE_W +: LANE_W]),
      .a_oe_o   (a_oe[l]),
      .b_oe_o   (b_oe[l])
    );
  end
endmodule

// File: tb/tb_bus_xcvr.sv
// Self-checking bench for bus_xcvr: latched instance plus a transparent twin.
module tb_bus_xcvr;
  localparam int LANES = 4;
  localparam int TURN  = 2;
  localparam int W     = 8 * LANES;

  logic             clk = 1'b0;
  logic             rstn;
  logic             dir_req;
  logic [LANES-1:0] oe_n_req;
  logic             le;
  logic [W-1:0]     a_i, b_i;
  logic [W-1:0]     a_o, b_o, a_o_t, b_o_t;
  logic [LANES-1:0] a_oe, b_oe, a_oe_t, b_oe_t;
  logic             dir, busy, dir_t, busy_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;

  always #5 clk = ~clk;

  bus_xcvr #(.LANES(LANES), .TURN(TURN), .LATCHED(1'b1)) dut (
    .clk(clk), .rstn(rstn), .dir_req(dir_req), .oe_n_req(oe_n_req), .le(le),
    .a_i(a_i), .b_i(b_i), .a_o(a_o), .b_o(b_o), .a_oe(a_oe), .b_oe(b_oe),
    .dir(dir), .busy(busy)
  );

  bus_xcvr #(.LANES(LANES), .TURN(TURN), .LATCHED(1'b0)) dut_t (
    .clk(clk), .rstn(rstn), .dir_req(dir_req), .oe_n_req(oe_n_req), .le(le),
    .a_i(a_i), .b_i(b_i), .a_o(a_o_t), .b_o(b_o_t), .a_oe(a_oe_t), .b_oe(b_oe_t),
    .dir(dir_t), .busy(busy_t)
  );

  always @(negedge clk)
    assert ((a_oe & b_oe) == '0) else $error("FAIL oe_overlap a_oe=%h b_oe=%h", a_oe, b_oe);

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    int n;
    rstn = 1'b0; dir_req = 1'b0; oe_n_req = '0; le = 1'b1;
    a_i = 32'h1122_3344; b_i = 32'h5566_7788;
    repeat (3) step;
    n_tests++;
    if ({busy, dir} !== 2'b10) begin
      n_fail++; $display("FAIL reset_ctl got busy,dir=%b%b want 10", busy, dir);
    end
    n_tests++;
    if ({a_oe, b_oe} !== '0) begin
      n_fail++; $display("FAIL reset_oe got a_oe=%h b_oe=%h want 0", a_oe, b_oe);
    end
    n_tests++;
    if ({a_o, b_o} !== '0) begin
      n_fail++; $display("FAIL reset_data got a_o=%h b_o=%h want 0", a_o, b_o);
    end
    rstn = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n_tests++;
      if ({a_oe, b_oe} !== '0) begin
        n_fail++; $display("FAIL release_dead_oe got a_oe=%h b_oe=%h want 0", a_oe, b_oe);
      end
      n++;
      step;
    end
    n_tests++;
    if (n != TURN) begin
      n_fail++; $display("FAIL release_busy_cycles got %0d want %0d", n, TURN);
    end
    n_tests++;
    if (a_oe !== 4'hF || b_oe !== 4'h0) begin
      n_fail++; $display("FAIL release_oe got a_oe=%h b_oe=%h want F/0", a_oe, b_oe);
    end
    n_tests++;
    if (a_o !== 32'h5566_7788) begin
      n_fail++; $display("FAIL release_ba_data got %h want 55667788", a_o);
    end
  endtask

  task automatic test_dir_change(input logic to);
    int n;
    logic [W-1:0] src;
    a_i = $urandom; b_i = $urandom; le = 1'b1;
    src = to ? a_i : b_i;
    dir_req = to;
    step;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n_tests++;
      if ({a_oe, b_oe} !== '0) begin
        n_fail++; $display("FAIL turn_dead_oe got a_oe=%h b_oe=%h want 0", a_oe, b_oe);
      end
      n++;
      step;
    end
    n_tests++;
    if (n != TURN) begin
      n_fail++; $display("FAIL turn_cycles got %0d want %0d", n, TURN);
    end
    n_tests++;
    if (dir !== to || (to ? b_oe : a_oe) !== 4'hF || (to ? a_oe : b_oe) !== 4'h0) begin
      n_fail++; $display("FAIL turn_end got dir=%b a_oe=%h b_oe=%h want dir=%b", dir, a_oe, b_oe, to);
    end
    n_tests++;
    if ((to ? b_o : a_o) !== src) begin
      n_fail++; $display("FAIL first_drive_data got %h want %h", to ? b_o : a_o, src);
    end
  endtask

  task automatic test_forward;
    logic [W-1:0] got, exp;
    le = 1'b1; a_i = 32'hA5F0_1234;
    exp_q.push_back(32'hA5F0_1234);
    step;
    exp = exp_q.pop_front(); got = b_o;
    n_tests++;
    if (got !== exp || a_o !== exp) begin
      n_fail++; $display("FAIL fwd_capture got b_o=%h a_o=%h want %h", got, a_o, exp);
    end
    le = 1'b0; a_i = '0;
    exp_q.push_back(32'hA5F0_1234);
    step;
    exp = exp_q.pop_front(); got = b_o;
    n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL fwd_hold got %h want %h", got, exp);
    end
    held = exp;
    for (int i = 0; i < 6; i++) begin
      le = 1'($urandom_range(0, 1)); a_i = $urandom; b_i = $urandom;
      if (le) held = a_i;
      exp_q.push_back(held);
      #1;
      n_tests++;
      if (b_o_t !== a_i || a_o_t !== b_i) begin
        n_fail++; $display("FAIL transparent got b_o=%h a_o=%h want %h %h", b_o_t, a_o_t, a_i, b_i);
      end
      step;
      exp = exp_q.pop_front(); got = b_o;
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL fwd_rand%0d got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_retarget;
    int n;
    dir_req = 1'b1;
    step;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n_tests++;
      if ({a_oe, b_oe} !== '0) begin
        n_fail++; $display("FAIL retarget_dead_oe got a_oe=%h b_oe=%h want 0", a_oe, b_oe);
      end
      n++;
      if (n == TURN) dir_req = 1'b0;
      step;
    end
    n_tests++;
    if (n != 2 * TURN) begin
      n_fail++; $display("FAIL retarget_cycles got %0d want %0d", n, 2 * TURN);
    end
    n_tests++;
    if (dir !== 1'b0 || a_oe !== 4'hF || b_oe !== 4'h0) begin
      n_fail++; $display("FAIL retarget_end got dir=%b a_oe=%h b_oe=%h want 0/F/0", dir, a_oe, b_oe);
    end
  endtask

  task automatic test_mask;
    logic [W-1:0] got, exp;
    oe_n_req = 4'b0101; le = 1'b1; a_i = $urandom;
    exp_q.push_back(a_i);
    step;
    n_tests++;
    if (b_oe !== 4'b1010 || a_oe !== 4'b0000) begin
      n_fail++; $display("FAIL mask_oe got b_oe=%b a_oe=%b want 1010/0000", b_oe, a_oe);
    end
    exp = exp_q.pop_front(); got = b_o;
    n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL mask_data got %h want %h", got, exp);
    end
    oe_n_req = '0;
  endtask

  task automatic test_async_reset;
    step;
    n_tests++;
    if (b_oe !== 4'hF) begin
      n_fail++; $display("FAIL pre_reset_oe got %h want F", b_oe);
    end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if (b_oe !== 4'h0 || a_oe !== 4'h0) begin
      n_fail++; $display("FAIL async_oe got a_oe=%h b_oe=%h want 0", a_oe, b_oe);
    end
    n_tests++;
    if (busy !== 1'b1 || dir !== 1'b0 || b_o !== '0) begin
      n_fail++; $display("FAIL async_state got busy=%b dir=%b b_o=%h want 1/0/0", busy, dir, b_o);
    end
    step;
    dir_req = 1'b0; rstn = 1'b1;
    step;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_dir_change(1'b1);
    test_forward;
    test_mask;
    test_dir_change(1'b0);
    test_retarget;
    test_dir_change(1'b1);
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
